// File: rtl/mouse_pos_tracker_if.sv
// Packet-in / position-out bundle between the PS/2 packet decoder and mouse_pos_tracker.
// The master side is the decoder plus the display logic; the slave side is the tracker.
interface mouse_pos_tracker_if #(
  parameter int unsigned W     = 10,
  parameter int unsigned N_LED = 8
);
  logic [8:0]       xm;
  logic [8:0]       ym;
  logic [2:0]       btnm;
  logic             m_done_tick;
  logic [W-1:0]     x_pos;
  logic [W-1:0]     y_pos;
  logic             frozen;
  logic [2:0]       btn_press;
  logic             upd_tick;
  logic [N_LED-1:0] led;

  modport master (
    output xm, ym, btnm, m_done_tick,
    input  x_pos, y_pos, frozen, btn_press, upd_tick, led
  );

  modport slave (
    input  xm, ym, btnm, m_done_tick,
    output x_pos, y_pos, frozen, btn_press, upd_tick, led
  );
endinterface

// File: rtl/mouse_pos_tracker.sv
// Cursor X/Y tracker fed by decoded PS/2 packets, with presets, freeze and an LED indicator.
// Optional macro MOUSE_TRK_ACCEL_EN doubles deltas with magnitude >= 16.
module mouse_pos_tracker #(
  parameter int unsigned W     = 10,
  parameter int unsigned N_LED = 8,
  parameter int unsigned SAT   = 1,
  parameter int unsigned BAR   = 0
) (
  input logic               clk,
  input logic               reset,
  mouse_pos_tracker_if.slave bus
);

  localparam int unsigned LW = $clog2(N_LED);
  // Wide enough for a doubled 9-bit delta even when W is small, so clamping stays exact.
  localparam int unsigned CW = (W + 2 > 12) ? W + 2 : 12;
  localparam logic [W-1:0]          PMAX   = '1;
  localparam logic signed [CW-1:0]  SMAX   = {{(CW-W){1'b0}}, PMAX};
  localparam logic signed [CW-1:0]  ACC_TH = CW'(16);

  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic             r_frozen;
  logic [2:0]       r_btn_prev;
  logic [2:0]       r_btn_press;
  logic             r_upd;

  logic [2:0]       w_press;
  logic [W-1:0]     w_x_nxt;
  logic [W-1:0]     w_y_nxt;
  logic [LW-1:0]    w_k;
  logic [N_LED-1:0] w_led;

  function automatic logic [W-1:0] f_step(input logic [W-1:0] pos, input logic [8:0] d);
    logic signed [CW-1:0] w_d;
    logic signed [CW-1:0] w_sum;
    w_d = {{(CW-9){d[8]}}, d};
`ifdef MOUSE_TRK_ACCEL_EN
    if (w_d >= ACC_TH || w_d <= -ACC_TH) begin
      w_d = w_d <<< 1;
    end
`endif
    w_sum = w_d + {{(CW-W){1'b0}}, pos};
    if (SAT != 0) begin
      if (w_sum < 0) begin
        return '0;
      end
      if (w_sum > SMAX) begin
        return PMAX;
      end
    end
    return w_sum[W-1:0];
  endfunction

  always_comb begin
    w_press = bus.btnm & ~r_btn_prev;
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (bus.btnm[0]) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end else if (bus.btnm[1]) begin
      w_x_nxt = PMAX;
      w_y_nxt = PMAX;
    end else if (!r_frozen) begin
      w_x_nxt = f_step(r_x, bus.xm);
      w_y_nxt = f_step(r_y, bus.ym);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_frozen    <= 1'b0;
      r_btn_prev  <= '0;
      r_btn_press <= '0;
      r_upd       <= 1'b0;
    end else begin
      r_upd <= bus.m_done_tick;
      if (bus.m_done_tick) begin
        r_x         <= w_x_nxt;
        r_y         <= w_y_nxt;
        r_frozen    <= r_frozen ^ w_press[2];
        r_btn_prev  <= bus.btnm;
        r_btn_press <= w_press;
      end else begin
        r_btn_press <= '0;
      end
    end
  end

  // LED index is the top log2(N_LED) bits of x; index 0 lights the MSB LED.
  always_comb begin
    w_k   = r_x[W-1 -: LW];
    w_led = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      if (BAR != 0) begin
        w_led[i] = (i >= int'(N_LED) - 1 - int'(w_k));
      end else begin
        w_led[i] = (i == int'(N_LED) - 1 - int'(w_k));
      end
    end
  end

  assign bus.x_pos     = r_x;
  assign bus.y_pos     = r_y;
  assign bus.frozen    = r_frozen;
  assign bus.btn_press = r_btn_press;
  assign bus.upd_tick  = r_upd;
  assign bus.led       = w_led;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Bench for mouse_pos_tracker: a saturating one-hot instance and a wrapping bar instance
// share directed and random packet stimulus, checked against an arithmetic reference model.
module tb_mouse_pos_tracker;

  localparam int unsigned W     = 10;
  localparam int unsigned N_LED = 8;
  localparam int          M     = 1 << W;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mouse_pos_tracker_if #(.W(W), .N_LED(N_LED)) bus0 ();
  mouse_pos_tracker_if #(.W(W), .N_LED(N_LED)) bus1 ();

  mouse_pos_tracker #(.W(W), .N_LED(N_LED), .SAT(1), .BAR(0)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  mouse_pos_tracker #(.W(W), .N_LED(N_LED), .SAT(0), .BAR(1)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         mx[2];
  int         my[2];
  bit         mfrz;
  logic [2:0] mprev;
  logic [2:0] mpress;
  bit         mupd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int move(input int pos, input logic [8:0] d, input bit sat);
    int dv;
    int r;
    dv = d[8] ? int'(d) - 512 : int'(d);
`ifdef MOUSE_TRK_ACCEL_EN
    if (dv >= 16 || dv <= -16) dv = dv * 2;
`endif
    r = pos + dv;
    if (sat) begin
      if (r < 0) r = 0;
      if (r > M - 1) r = M - 1;
    end else begin
      r = r & (M - 1);
    end
    return r;
  endfunction

  function automatic int led_exp(input int x, input bit bar);
    int k;
    int v;
    k = x / (M / N_LED);
    v = 0;
    for (int i = 0; i < int'(N_LED); i++) begin
      if (bar ? (i >= N_LED - 1 - k) : (i == N_LED - 1 - k)) v = v | (1 << i);
    end
    return v;
  endfunction

  function automatic void model_reset();
    mx[0] = 0; mx[1] = 0; my[0] = 0; my[1] = 0;
    mfrz = 1'b0; mprev = '0; mpress = '0; mupd = 1'b0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "/x_sat"},   32'(bus0.x_pos),     32'(mx[0]));
    check({tag, "/y_sat"},   32'(bus0.y_pos),     32'(my[0]));
    check({tag, "/x_wrap"},  32'(bus1.x_pos),     32'(mx[1]));
    check({tag, "/y_wrap"},  32'(bus1.y_pos),     32'(my[1]));
    check({tag, "/frozen"},  {bus1.frozen, bus0.frozen}, {2{mfrz}});
    check({tag, "/press0"},  32'(bus0.btn_press), 32'(mpress));
    check({tag, "/press1"},  32'(bus1.btn_press), 32'(mpress));
    check({tag, "/upd"},     {bus1.upd_tick, bus0.upd_tick}, {2{mupd}});
    check({tag, "/led_oh"},  32'(bus0.led),       32'(led_exp(mx[0], 1'b0)));
    check({tag, "/led_bar"}, 32'(bus1.led),       32'(led_exp(mx[1], 1'b1)));
  endtask

  task automatic set_inputs(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b,
                            input logic v);
    bus0.xm = x; bus0.ym = y; bus0.btnm = b; bus0.m_done_tick = v;
    bus1.xm = x; bus1.ym = y; bus1.btnm = b; bus1.m_done_tick = v;
  endtask

  // One clock cycle: apply inputs at a falling edge, then compare at the next falling edge.
  task automatic step(input string tag, input logic [8:0] x, input logic [8:0] y,
                      input logic [2:0] b, input logic v);
    logic [2:0] p;
    set_inputs(x, y, b, v);
    @(negedge clk);
    if (v) begin
      p = b & ~mprev;
      mpress = p;
      mprev  = b;
      for (int i = 0; i < 2; i++) begin
        if (b[0]) begin
          mx[i] = 0; my[i] = 0;
        end else if (b[1]) begin
          mx[i] = M - 1; my[i] = M - 1;
        end else if (!mfrz) begin
          mx[i] = move(mx[i], x, i == 0);
          my[i] = move(my[i], y, i == 0);
        end
      end
      mfrz = mfrz ^ p[2];
      mupd = 1'b1;
    end else begin
      mpress = '0;
      mupd   = 1'b0;
    end
    compare_all(tag);
  endtask

  initial begin
    logic [2:0] rb;
    model_reset();
    set_inputs('0, '0, '0, 1'b0);
    #1;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b1;

    step("tp1", 9'd5, 9'h1FD, 3'b000, 1'b1);
    check("tp1_x", 32'(bus0.x_pos), 32'd5);
    check("tp1_y_clamp", 32'(bus0.y_pos), 32'd0);
    step("tp1_idle", 9'd0, 9'd0, 3'b000, 1'b0);

    step("right", 9'd0, 9'd0, 3'b010, 1'b1);
    step("to1020", 9'h1FD, 9'd0, 3'b000, 1'b1);
    step("wrap_x", 9'd10, 9'd0, 3'b000, 1'b1);
    check("tp2_x_wrap", 32'(bus1.x_pos), 32'd6);
    check("tp2_x_sat", 32'(bus0.x_pos), 32'd1023);
    step("left", 9'd0, 9'd0, 3'b001, 1'b1);
    step("wrap_y", 9'd0, 9'h1FF, 3'b000, 1'b1);
    check("tp2_y_wrap", 32'(bus1.y_pos), 32'd1023);

    step("lr", 9'd0, 9'd0, 3'b011, 1'b1);
    check("tp3_press", 32'(bus0.btn_press), 32'd3);
    step("lr_hold", 9'd7, 9'd0, 3'b011, 1'b1);
    check("tp3_x", 32'(bus0.x_pos), 32'd0);

    step("frz_on", 9'd0, 9'd0, 3'b100, 1'b1);
    check("tp4_frozen", 32'(bus0.frozen), 32'd1);
    step("frz_move", 9'd20, 9'd0, 3'b000, 1'b1);
    step("frz_off", 9'd0, 9'd0, 3'b100, 1'b1);
    step("unfrz_move", 9'd20, 9'd0, 3'b000, 1'b1);
`ifdef MOUSE_TRK_ACCEL_EN
    check("tp4_x", 32'(bus0.x_pos), 32'd40);
`else
    check("tp4_x", 32'(bus0.x_pos), 32'd20);
`endif

    step("led_zero", 9'd0, 9'd0, 3'b001, 1'b1);
`ifdef MOUSE_TRK_ACCEL_EN
    step("led_a", 9'd96, 9'd0, 3'b000, 1'b1);
    step("led_b", 9'd96, 9'd0, 3'b000, 1'b1);
`else
    step("led_a", 9'd255, 9'd0, 3'b000, 1'b1);
    step("led_b", 9'd129, 9'd0, 3'b000, 1'b1);
`endif
    check("tp5_x", 32'(bus0.x_pos), 32'h180);
    check("tp5_led_oh", 32'(bus0.led), 32'b00010000);
    check("tp5_led_bar", 32'(bus1.led), 32'b11110000);

    // Reset lands between a strobe and its update edge.
    step("pre_rst", 9'd0, 9'd0, 3'b100, 1'b1);
    set_inputs(9'd5, 9'd5, 3'b100, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("rst_mid");
    @(negedge clk);
    set_inputs('0, '0, '0, 1'b0);
    compare_all("rst_hold");
    reset = 1'b1;
    step("post_rst", 9'd0, 9'd0, 3'b000, 1'b0);
    step("post_rst_press", 9'd0, 9'd0, 3'b100, 1'b1);
    check("tp6_press", 32'(bus0.btn_press), 32'd4);

    for (int n = 0; n < 400; n++) begin
      rb = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      step("rand", 9'($urandom), 9'($urandom), rb, 1'($urandom_range(0, 2) != 0));
    end
    step("final_idle", 9'd0, 9'd0, 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
